// File: rtl/div_pwm_if.sv
// Bundles the div_pwm control, divided-clock and PWM output signals.
// The master drives control, the slave (div_pwm) returns the PWM outputs.
interface div_pwm_if #(
    parameter int W = 8
);
    logic         en;
    logic [1:0]   sel;
    logic         clk2;
    logic         clk4;
    logic         clk8;
    logic [W-1:0] duty;
    logic         load;
    logic         pwm_out;
    logic         tick_out;
    logic         period_done;

    modport master (
        output en, sel, clk2, clk4, clk8, duty, load,
        input  pwm_out, tick_out, period_done
    );

    modport slave (
        input  en, sel, clk2, clk4, clk8, duty, load,
        output pwm_out, tick_out, period_done
    );
endinterface

// File: rtl/div_pwm.sv
// PWM generator: a 2^W-tick period counter advanced by a selectable tick source,
// with a shadowed duty register that is applied at the period wrap.
module div_pwm #(
    parameter int W = 8
) (
    input  logic       clk,
    input  logic       rst,
    div_pwm_if.slave   bus
);
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [W-1:0] CNT_MAX = {W{1'b1}};
    localparam logic [W-1:0] CNT_ONE = {{(W-1){1'b0}}, 1'b1};

    state_t       state_r;
    logic [W-1:0] cnt_r;
    logic [W-1:0] duty_act_r;
    logic [W-1:0] duty_sh_r;
    logic         pending_r;
    logic         prev2_r;
    logic         prev4_r;
    logic         prev8_r;
    logic         pwm_r;
    logic         tick_r;
    logic         done_r;
    logic         tick_s;
    logic         wrap_s;

    // Selected tick: rising edge of the chosen divided clock, or every cycle.
    always_comb begin
        tick_s = 1'b0;
        case (bus.sel)
            2'd0:    tick_s = 1'b1;
            2'd1:    tick_s = bus.clk2 & ~prev2_r;
            2'd2:    tick_s = bus.clk4 & ~prev4_r;
            2'd3:    tick_s = bus.clk8 & ~prev8_r;
            default: tick_s = 1'b0;
        endcase
    end

    // A wrap only counts while running and staying enabled.
    always_comb begin
        if ((state_r == RUN) && bus.en && tick_s && (cnt_r == CNT_MAX)) begin
            wrap_s = 1'b1;
        end else begin
            wrap_s = 1'b0;
        end
    end

    // Run/idle FSM, counter, duty shadowing and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            cnt_r      <= '0;
            duty_act_r <= '0;
            duty_sh_r  <= '0;
            pending_r  <= 1'b0;
            prev2_r    <= 1'b0;
            prev4_r    <= 1'b0;
            prev8_r    <= 1'b0;
            pwm_r      <= 1'b0;
            tick_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            // Edge detectors track their inputs unconditionally so a sel change never fakes a rise.
            prev2_r <= bus.clk2;
            prev4_r <= bus.clk4;
            prev8_r <= bus.clk8;
            pwm_r   <= 1'b0;
            tick_r  <= 1'b0;
            done_r  <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (bus.load) begin
                        duty_act_r <= bus.duty;
                        duty_sh_r  <= bus.duty;
                        pending_r  <= 1'b0;
                    end
                    if (bus.en) begin
                        state_r <= RUN;
                    end
                end
                RUN: begin
                    if (bus.en) begin
                        pwm_r <= (cnt_r < duty_act_r);
                        if (tick_s) begin
                            cnt_r  <= cnt_r + CNT_ONE;
                            tick_r <= 1'b1;
                            done_r <= wrap_s;
                        end
                        if (wrap_s && bus.load) begin
                            duty_act_r <= bus.duty;
                            duty_sh_r  <= bus.duty;
                            pending_r  <= 1'b0;
                        end else if (wrap_s) begin
                            if (pending_r) begin
                                duty_act_r <= duty_sh_r;
                            end
                            pending_r <= 1'b0;
                        end else if (bus.load) begin
                            duty_sh_r <= bus.duty;
                            pending_r <= 1'b1;
                        end
                    end else begin
                        // Leaving RUN wins over any tick in the same cycle.
                        state_r <= IDLE;
                        cnt_r   <= '0;
                        if (bus.load) begin
                            duty_sh_r <= bus.duty;
                            pending_r <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= '0;
                end
            endcase
        end
    end

    assign bus.pwm_out     = pwm_r;
    assign bus.tick_out    = tick_r;
    assign bus.period_done = done_r;
endmodule

// File: tb/tb_div_pwm.sv
// Self-checking bench for div_pwm: directed period scenarios plus randomized
// stimulus, all compared cycle by cycle against a behavioural PWM model.
module tb_div_pwm;
    localparam int W      = 8;
    localparam int PERIOD = 1 << W;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;
    int   divc;
    bit   div_auto;

    div_pwm_if #(.W(W)) bus ();

    div_pwm #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running system clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: running flag, phase in ticks, active/shadow duty, last seen divided levels.
    bit m_run;
    int m_phase;
    int m_duty;
    int m_shadow;
    bit m_pend;
    bit m_l2, m_l4, m_l8;
    bit e_pwm, e_tick, e_done;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step();
        bit tk;
        bit wrap;
        if (rst) begin
            m_run = 0; m_phase = 0; m_duty = 0; m_shadow = 0; m_pend = 0;
            m_l2 = 0; m_l4 = 0; m_l8 = 0;
            e_pwm = 0; e_tick = 0; e_done = 0;
            return;
        end
        case (int'(bus.sel))
            0:       tk = 1;
            1:       tk = bus.clk2 && !m_l2;
            2:       tk = bus.clk4 && !m_l4;
            default: tk = bus.clk8 && !m_l8;
        endcase
        m_l2 = bus.clk2; m_l4 = bus.clk4; m_l8 = bus.clk8;
        e_pwm = 0; e_tick = 0; e_done = 0;
        if (m_run && bus.en) begin
            e_pwm  = (m_phase < m_duty);
            wrap   = tk && (m_phase == PERIOD - 1);
            e_tick = tk;
            e_done = wrap;
            if (tk) m_phase = (m_phase + 1) % PERIOD;
            if (wrap && bus.load) begin
                m_duty = int'(bus.duty); m_shadow = int'(bus.duty); m_pend = 0;
            end else if (wrap) begin
                if (m_pend) m_duty = m_shadow;
                m_pend = 0;
            end else if (bus.load) begin
                m_shadow = int'(bus.duty); m_pend = 1;
            end
        end else if (m_run) begin
            m_run = 0; m_phase = 0;
            if (bus.load) begin
                m_shadow = int'(bus.duty); m_pend = 1;
            end
        end else begin
            if (bus.load) begin
                m_duty = int'(bus.duty); m_shadow = int'(bus.duty); m_pend = 0;
            end
            if (bus.en) m_run = 1;
        end
    endtask

    // One clock: advance the divider, predict, clock the DUT, compare at the falling edge.
    task automatic step();
        if (div_auto) begin
            bus.clk2 = divc[0];
            bus.clk4 = divc[1];
            bus.clk8 = divc[2];
        end
        divc++;
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_val("pwm_out", int'(bus.pwm_out), int'(e_pwm));
        check_val("tick_out", int'(bus.tick_out), int'(e_tick));
        check_val("period_done", int'(bus.period_done), int'(e_done));
    endtask

    task automatic idle_load(input int d);
        bus.en   = 1'b0;
        step();
        bus.load = 1'b1;
        bus.duty = W'(d);
        step();
        bus.load = 1'b0;
        bus.en   = 1'b1;
        step();
    endtask

    task automatic count_window(input int n, output int highs, output int ticks, output int dones);
        highs = 0; ticks = 0; dones = 0;
        for (int k = 0; k < n; k++) begin
            step();
            highs += int'(bus.pwm_out);
            ticks += int'(bus.tick_out);
            dones += int'(bus.period_done);
        end
    endtask

    initial begin
        int hi, tk, dn, guard;
        n_checks = 0; n_pass = 0; divc = 0; div_auto = 1;
        rst = 1'b1;
        bus.en = 1'b1; bus.sel = 2'd0; bus.duty = 8'd77; bus.load = 1'b1;
        bus.clk2 = 1'b0; bus.clk4 = 1'b0; bus.clk8 = 1'b0;
        @(negedge clk);
        step();
        check_val("rst_pwm", int'(bus.pwm_out), 0);
        check_val("rst_tick", int'(bus.tick_out), 0);
        check_val("rst_done", int'(bus.period_done), 0);
        rst = 1'b0; bus.load = 1'b0;

        // sel=0, duty 64: 64 high / 192 low, wrap every 256 cycles.
        bus.sel = 2'd0;
        idle_load(64);
        count_window(512, hi, tk, dn);
        check_val("d64_high", hi, 128);
        check_val("d64_done", dn, 2);

        // Shadowed load mid-period applies only after the wrap.
        guard = 0;
        while (m_phase != 10 && guard < 600) begin step(); guard++; end
        check_val("reach_cnt10", int'(m_phase == 10), 1);
        bus.load = 1'b1; bus.duty = 8'd200;
        step();
        bus.load = 1'b0;
        guard = 0;
        while (!bus.period_done && guard < 600) begin step(); guard++; end
        check_val("wrap_seen", int'(bus.period_done), 1);
        count_window(256, hi, tk, dn);
        check_val("d200_high", hi, 200);

        // en dropped at cnt=100.
        guard = 0;
        while (m_phase != 100 && guard < 600) begin step(); guard++; end
        bus.en = 1'b0;
        step();
        check_val("drop_pwm", int'(bus.pwm_out), 0);
        check_val("drop_done", int'(bus.period_done), 0);
        bus.en = 1'b1;
        step();
        count_window(256, hi, tk, dn);
        check_val("reen_high", hi, 200);
        check_val("reen_done", dn, 1);

        // Duty boundaries.
        idle_load(0);
        count_window(256, hi, tk, dn);
        check_val("d0_high", hi, 0);
        idle_load(255);
        count_window(256, hi, tk, dn);
        check_val("d255_low", 256 - hi, 1);

        // sel=3 with clk8 period 8, duty 2.
        bus.sel = 2'd3;
        idle_load(2);
        count_window(64, hi, tk, dn);
        check_val("s3_ticks", tk, 8);
        count_window(2048, hi, tk, dn);
        check_val("s3_high", hi, 16);
        check_val("s3_done", dn, 1);

        // Randomized phase.
        for (int i = 0; i < 15000; i++) begin
            rst = ($urandom_range(2999, 0) == 0);
            if (bus.en) bus.en = ($urandom_range(399, 0) != 0);
            else        bus.en = ($urandom_range(7, 0) == 0);
            if ($urandom_range(299, 0) == 0) bus.sel = 2'($urandom_range(3, 0));
            if ($urandom_range(499, 0) == 0) div_auto = ~div_auto;
            if (!div_auto) begin
                bus.clk2 = 1'($urandom); bus.clk4 = 1'($urandom); bus.clk8 = 1'($urandom);
            end
            bus.load = ($urandom_range(63, 0) == 0);
            case ($urandom_range(7, 0))
                0:       bus.duty = 8'd0;
                1:       bus.duty = 8'd255;
                default: bus.duty = 8'($urandom_range(255, 0));
            endcase
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
